mc_control_unit: RTL

- Multi-cycle control FSM for the 16-bit TSC CPU. It replaces the single-cycle decoder with a sequencer.
- Stages: IF, ID, EX, MEM, WB, HALT. Drives all datapath selects and register/PC/IR enables.
- Owns the memory read/write request handshake against a shared unified memory.
- Counts completed instructions.

---
 rtl/mc_control_unit_pkg.sv | 129 ++++++++++++
 rtl/mc_control_unit_alu_decode.sv | 36 +++
 rtl/mc_control_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle TSC control unit: ISA opcodes, ALU codes,
// FSM states, datapath select values and the control bundle.
package mc_control_unit_pkg;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned FUNC_W   = 6;
    localparam int unsigned ALU_OP_W = 4;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPC_W-1:0] OPCODE_BNE = 4'd0;
    localparam logic [OPC_W-1:0] OPCODE_BEQ = 4'd1;
    localparam logic [OPC_W-1:0] OPCODE_BGZ = 4'd2;
    localparam logic [OPC_W-1:0] OPCODE_BLZ = 4'd3;
    localparam logic [OPC_W-1:0] OPCODE_ADI = 4'd4;
    localparam logic [OPC_W-1:0] OPCODE_ORI = 4'd5;
    localparam logic [OPC_W-1:0] OPCODE_LHI = 4'd6;
    localparam logic [OPC_W-1:0] OPCODE_LWD = 4'd7;
    localparam logic [OPC_W-1:0] OPCODE_SWD = 4'd8;
    localparam logic [OPC_W-1:0] OPCODE_JMP = 4'd9;
    localparam logic [OPC_W-1:0] OPCODE_JAL = 4'd10;
    localparam logic [OPC_W-1:0] TYPE_R     = 4'd15;

    localparam logic [FUNC_W-1:0] FUNC_ADD = 6'd0;
    localparam logic [FUNC_W-1:0] FUNC_SUB = 6'd1;
    localparam logic [FUNC_W-1:0] FUNC_AND = 6'd2;
    localparam logic [FUNC_W-1:0] FUNC_ORR = 6'd3;
    localparam logic [FUNC_W-1:0] FUNC_NOT = 6'd4;
    localparam logic [FUNC_W-1:0] FUNC_TCP = 6'd5;
    localparam logic [FUNC_W-1:0] FUNC_SHL = 6'd6;
    localparam logic [FUNC_W-1:0] FUNC_SHR = 6'd7;
    localparam logic [FUNC_W-1:0] FUNC_JPR = 6'd25;
    localparam logic [FUNC_W-1:0] FUNC_JRL = 6'd26;
    localparam logic [FUNC_W-1:0] FUNC_WWD = 6'd28;
    localparam logic [FUNC_W-1:0] FUNC_HLT = 6'd29;

    localparam logic [ALU_OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [ALU_OP_W-1:0] OP_AND = 4'd2;
    localparam logic [ALU_OP_W-1:0] OP_ORR = 4'd3;
    localparam logic [ALU_OP_W-1:0] OP_NOT = 4'd4;
    localparam logic [ALU_OP_W-1:0] OP_TCP = 4'd5;
    localparam logic [ALU_OP_W-1:0] OP_SHL = 4'd6;
    localparam logic [ALU_OP_W-1:0] OP_SHR = 4'd7;
    localparam logic [ALU_OP_W-1:0] OP_LHI = 4'd8;
    localparam logic [ALU_OP_W-1:0] OP_BNE = 4'd9;
    localparam logic [ALU_OP_W-1:0] OP_BEQ = 4'd10;
    localparam logic [ALU_OP_W-1:0] OP_BGZ = 4'd11;
    localparam logic [ALU_OP_W-1:0] OP_BLZ = 4'd12;

    localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [SEL_W-1:0] PC_SRC_RS     = 2'd3;

    localparam logic [SEL_W-1:0] ALU_B_RT   = 2'd0;
    localparam logic [SEL_W-1:0] ALU_B_ONE  = 2'd1;
    localparam logic [SEL_W-1:0] ALU_B_SEXT = 2'd2;
    localparam logic [SEL_W-1:0] ALU_B_ZEXT = 2'd3;

    localparam logic [SEL_W-1:0] REG_DST_RT = 2'd0;
    localparam logic [SEL_W-1:0] REG_DST_RD = 2'd1;
    localparam logic [SEL_W-1:0] REG_DST_R2 = 2'd2;

    localparam logic [SEL_W-1:0] WB_SRC_ALUOUT = 2'd0;
    localparam logic [SEL_W-1:0] WB_SRC_MDR    = 2'd1;
    localparam logic [SEL_W-1:0] WB_SRC_PC     = 2'd2;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP, CLS_RTYPE, CLS_ADI, CLS_ORI, CLS_LHI, CLS_LWD, CLS_SWD,
        CLS_BRANCH, CLS_JMP, CLS_JAL, CLS_JPR, CLS_JRL, CLS_WWD, CLS_HLT
    } instr_class_e;

    typedef struct packed {
        logic                read_m;
        logic                write_m;
        logic                i_or_d;
        logic                ir_write;
        logic                pc_write;
        logic [SEL_W-1:0]    pc_src;
        logic                alu_src_a;
        logic [SEL_W-1:0]    alu_src_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic                reg_write;
        logic [SEL_W-1:0]    reg_dst;
        logic [SEL_W-1:0]    wb_src;
        logic                output_port_en;
        logic                is_halted;
    } ctrl_t;

    // Anything not listed here decodes as a NOP.
    function automatic instr_class_e decode_class(input logic [OPC_W-1:0]  opcode,
                                                  input logic [FUNC_W-1:0] func_code);
        instr_class_e cls;
        cls = CLS_NOP;
        case (opcode)
            OPCODE_BNE, OPCODE_BEQ, OPCODE_BGZ, OPCODE_BLZ: cls = CLS_BRANCH;
            OPCODE_ADI: cls = CLS_ADI;
            OPCODE_ORI: cls = CLS_ORI;
            OPCODE_LHI: cls = CLS_LHI;
            OPCODE_LWD: cls = CLS_LWD;
            OPCODE_SWD: cls = CLS_SWD;
            OPCODE_JMP: cls = CLS_JMP;
            OPCODE_JAL: cls = CLS_JAL;
            TYPE_R: begin
                case (func_code)
                    FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_ORR,
                    FUNC_NOT, FUNC_TCP, FUNC_SHL, FUNC_SHR: cls = CLS_RTYPE;
                    FUNC_JPR: cls = CLS_JPR;
                    FUNC_JRL: cls = CLS_JRL;
                    FUNC_WWD: cls = CLS_WWD;
                    FUNC_HLT: cls = CLS_HLT;
                    default:  cls = CLS_NOP;
                endcase
            end
            default: cls = CLS_NOP;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_control_unit_alu_decode.sv
// Combinational opcode/func to ALU operation decode used in the EX stage.
module mc_alu_decode
    import mc_control_unit_pkg::*;
(
    input  logic [OPC_W-1:0]    i_opcode,
    input  logic [FUNC_W-1:0]   i_func_code,
    output logic [ALU_OP_W-1:0] o_alu_op
);

    always_comb begin
        o_alu_op = OP_ADD;
        case (i_opcode)
            TYPE_R: begin
                case (i_func_code)
                    FUNC_ADD: o_alu_op = OP_ADD;
                    FUNC_SUB: o_alu_op = OP_SUB;
                    FUNC_AND: o_alu_op = OP_AND;
                    FUNC_ORR: o_alu_op = OP_ORR;
                    FUNC_NOT: o_alu_op = OP_NOT;
                    FUNC_TCP: o_alu_op = OP_TCP;
                    FUNC_SHL: o_alu_op = OP_SHL;
                    FUNC_SHR: o_alu_op = OP_SHR;
                    default:  o_alu_op = OP_ADD;
                endcase
            end
            OPCODE_ORI: o_alu_op = OP_ORR;
            OPCODE_LHI: o_alu_op = OP_LHI;
            OPCODE_BNE: o_alu_op = OP_BNE;
            OPCODE_BEQ: o_alu_op = OP_BEQ;
            OPCODE_BGZ: o_alu_op = OP_BGZ;
            OPCODE_BLZ: o_alu_op = OP_BLZ;
            default:    o_alu_op = OP_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle TSC sequencer: IF/ID/EX/MEM/WB/HALT, drives datapath selects and
// enables, owns the memory request handshake and counts retired instructions.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned CNT_W     = WORD_SIZE
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [FUNC_W-1:0]   func_code,
    input  logic                bcond,
    input  logic                mem_ready,
    output logic                read_m,
    output logic                write_m,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic [SEL_W-1:0]    pc_src,
    output logic                alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_write,
    output logic [SEL_W-1:0]    reg_dst,
    output logic [SEL_W-1:0]    wb_src,
    output logic                output_port_en,
    output logic                is_halted,
    output logic [CNT_W-1:0]    num_inst
);

    state_e              r_state;
    state_e              w_next_state;
    instr_class_e        w_class;
    logic [ALU_OP_W-1:0] w_alu_op;
    logic                w_complete;
    logic [CNT_W-1:0]    r_num_inst;
    ctrl_t               w_ctrl;
    ctrl_t               w_ctrl_out;

    assign w_class = decode_class(opcode, func_code);

    mc_alu_decode u_alu_decode (
        .i_opcode    (opcode),
        .i_func_code (func_code),
        .o_alu_op    (w_alu_op)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IF: begin
                if (mem_ready) begin
                    w_next_state = ST_ID;
                end
            end
            ST_ID: begin
                case (w_class)
                    CLS_JMP, CLS_JAL, CLS_JPR, CLS_JRL, CLS_NOP: w_next_state = ST_IF;
                    CLS_HLT: w_next_state = ST_HALT;
                    default: w_next_state = ST_EX;
                endcase
            end
            ST_EX: begin
                case (w_class)
                    CLS_LWD, CLS_SWD: w_next_state = ST_MEM;
                    CLS_RTYPE, CLS_ADI, CLS_ORI, CLS_LHI: w_next_state = ST_WB;
                    default: w_next_state = ST_IF;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    w_next_state = (w_class == CLS_LWD) ? ST_WB : ST_IF;
                end
            end
            ST_WB:   w_next_state = ST_IF;
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_IF;
        endcase
    end

    // An instruction retires whenever a working stage hands back to IF or HALT.
    assign w_complete = (r_state != ST_IF) && (r_state != ST_HALT) &&
                        ((w_next_state == ST_IF) || (w_next_state == ST_HALT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_num_inst <= '0;
        end else if (w_complete) begin
            r_num_inst <= r_num_inst + CNT_W'(1);
        end
    end

    always_comb begin
        w_ctrl = '0;
        case (r_state)
            ST_IF: begin
                w_ctrl.read_m    = 1'b1;
                w_ctrl.alu_src_b = ALU_B_ONE;
                w_ctrl.alu_op    = OP_ADD;
                if (mem_ready) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_ctrl.pc_src   = PC_SRC_ALU;
                end
            end
            ST_ID: begin
                w_ctrl.alu_src_b = ALU_B_SEXT;
                w_ctrl.alu_op    = OP_ADD;
                case (w_class)
                    CLS_JMP: begin
                        w_ctrl.pc_write = 1'b1;
                        w_ctrl.pc_src   = PC_SRC_JUMP;
                    end
                    CLS_JAL: begin
                        w_ctrl.pc_write  = 1'b1;
                        w_ctrl.pc_src    = PC_SRC_JUMP;
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.reg_dst   = REG_DST_R2;
                        w_ctrl.wb_src    = WB_SRC_PC;
                    end
                    CLS_JPR: begin
                        w_ctrl.pc_write = 1'b1;
                        w_ctrl.pc_src   = PC_SRC_RS;
                    end
                    CLS_JRL: begin
                        w_ctrl.pc_write  = 1'b1;
                        w_ctrl.pc_src    = PC_SRC_RS;
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.reg_dst   = REG_DST_R2;
                        w_ctrl.wb_src    = WB_SRC_PC;
                    end
                    default: ;
                endcase
            end
            ST_EX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = w_alu_op;
                case (w_class)
                    CLS_ADI, CLS_LWD, CLS_SWD: w_ctrl.alu_src_b = ALU_B_SEXT;
                    CLS_ORI, CLS_LHI:          w_ctrl.alu_src_b = ALU_B_ZEXT;
                    CLS_BRANCH: begin
                        w_ctrl.alu_src_b = ALU_B_RT;
                        if (bcond) begin
                            w_ctrl.pc_write = 1'b1;
                            w_ctrl.pc_src   = PC_SRC_ALUOUT;
                        end
                    end
                    CLS_WWD: w_ctrl.output_port_en = 1'b1;
                    default: w_ctrl.alu_src_b = ALU_B_RT;
                endcase
            end
            ST_MEM: begin
                w_ctrl.i_or_d  = 1'b1;
                w_ctrl.read_m  = (w_class == CLS_LWD);
                w_ctrl.write_m = (w_class == CLS_SWD);
            end
            ST_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = (w_class == CLS_RTYPE) ? REG_DST_RD : REG_DST_RT;
                w_ctrl.wb_src    = (w_class == CLS_LWD) ? WB_SRC_MDR : WB_SRC_ALUOUT;
            end
            ST_HALT: w_ctrl.is_halted = 1'b1;
            default: ;
        endcase
    end

    // Reset forces every control line low immediately, even mid-handshake.
    assign w_ctrl_out = reset_n ? w_ctrl : '0;

    assign read_m         = w_ctrl_out.read_m;
    assign write_m        = w_ctrl_out.write_m;
    assign i_or_d         = w_ctrl_out.i_or_d;
    assign ir_write       = w_ctrl_out.ir_write;
    assign pc_write       = w_ctrl_out.pc_write;
    assign pc_src         = w_ctrl_out.pc_src;
    assign alu_src_a      = w_ctrl_out.alu_src_a;
    assign alu_src_b      = w_ctrl_out.alu_src_b;
    assign alu_op         = w_ctrl_out.alu_op;
    assign reg_write      = w_ctrl_out.reg_write;
    assign reg_dst        = w_ctrl_out.reg_dst;
    assign wb_src         = w_ctrl_out.wb_src;
    assign output_port_en = w_ctrl_out.output_port_en;
    assign is_halted      = w_ctrl_out.is_halted;
    assign num_inst       = r_num_inst;

endmodule
